// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO; frames go out LSB-first, back-to-back.
// Optional parity bit is built in with `define UART_TX_PARITY_EN (adds the parity_odd port).
module uart_tx_fifo #(
    parameter int DBIT    = 8,
    parameter int OS_TICK = 16,
    parameter int SB_TICK = 16,
    parameter int FIFO_AW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            wr_en,
    input  logic [DBIT-1:0] din,
`ifdef UART_TX_PARITY_EN
    input  logic            parity_odd,
`endif
    output logic            full,
    output logic            empty,
    output logic            busy,
    output logic            tx_done_tick,
    output logic            tx
);

    localparam int          DEPTH   = 2 ** FIFO_AW;
    localparam logic [5:0]  OS_LAST = 6'(OS_TICK - 1);
    localparam logic [5:0]  SB_LAST = 6'(SB_TICK - 1);
    localparam logic [3:0]  N_LAST  = 4'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [DBIT-1:0]    mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               full_q, empty_q;
    logic               push, pop;
    logic [DBIT-1:0]    head;

    state_t             state_q, state_d;
    logic [5:0]         s_cnt_q, s_cnt_d;
    logic [3:0]         n_cnt_q, n_cnt_d;
    logic [DBIT-1:0]    shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    // full is registered, so a write on the same edge as a pop from a full FIFO is still dropped
    assign push = wr_en && !full_q;
    assign head = mem_q[rptr_q];
    assign cnt_d = cnt_q + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= din;
        end
    end

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty_q) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (s_tick) begin
                    if (s_cnt_q == OS_LAST) begin
                        state_d = S_DATA;
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                        tx_d    = shift_q[0];
                    end else begin
                        s_cnt_d = s_cnt_q + 6'd1;
                    end
                end
            end
            S_DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == OS_LAST) begin
                        s_cnt_d = '0;
                        shift_d = shift_q >> 1;
                        n_cnt_d = n_cnt_q + 4'd1;
                        if (n_cnt_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = S_PARITY;
                            tx_d    = par_q;
`else
                            state_d = S_STOP;
                            tx_d    = 1'b1;
`endif
                        end else begin
                            tx_d = shift_q[1];
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 6'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (s_tick) begin
                    if (s_cnt_q == OS_LAST) begin
                        state_d = S_STOP;
                        s_cnt_d = '0;
                        tx_d    = 1'b1;
                    end else begin
                        s_cnt_d = s_cnt_q + 6'd1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == SB_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        pop     = !empty_q;
                    end else begin
                        s_cnt_d = s_cnt_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // Loading the next word overrides the idle/stop exit so frames chain with no gap
        if (pop) begin
            state_d = S_START;
            shift_d = head;
            s_cnt_d = '0;
            tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head ^ parity_odd;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            state_q <= S_IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            if (push) begin
                wptr_q <= wptr_q + FIFO_AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + FIFO_AW'(1);
            end
            cnt_q   <= cnt_d;
            full_q  <= cnt_d[FIFO_AW];
            empty_q <= (cnt_d == '0);
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign busy         = (state_q != S_IDLE);
    assign tx_done_tick = done_q;
    assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-and-tick-count model predicts the line, flags and done pulse every clock.
// Builds with or without UART_TX_PARITY_EN.
module tb_uart_tx_fifo;

    localparam int DBIT    = 8;
    localparam int OS_TICK = 16;
    localparam int SB_TICK = 16;
    localparam int FIFO_AW = 2;
    localparam int DEPTH   = 2 ** FIFO_AW;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME_TICKS = (1 + DBIT + P) * OS_TICK + SB_TICK;

    // clock / reset
    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            s_tick = 1'b0;
    logic            wr_en = 1'b0;
    logic [DBIT-1:0] din = '0;
    logic            parity_odd = 1'b0;
    logic            full, empty, busy, tx_done_tick, tx;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DBIT(DBIT), .OS_TICK(OS_TICK), .SB_TICK(SB_TICK), .FIFO_AW(FIFO_AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_tick(s_tick),
        .wr_en(wr_en),
        .din(din),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .full(full),
        .empty(empty),
        .busy(busy),
        .tx_done_tick(tx_done_tick),
        .tx(tx)
    );

    // scoreboard / reference model state
    logic [DBIT-1:0] exp_q[$];
    bit              m_busy = 1'b0;
    int              m_left = 0;
    logic [DBIT-1:0] m_word = '0;
    logic            m_par = 1'b0;
    bit              m_done = 1'b0;
    int              tick_div = 0;
    bit              tick_hold = 1'b0;
    bit              tick_rand = 1'b0;
    int              done_seen = 0;
    int              total = 0;
    int              bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Line level implied by how many ticks of the current frame have elapsed
    function automatic logic line_bit();
        int e;
        int b;
        if (!m_busy) return 1'b1;
        e = FRAME_TICKS - m_left;
        b = e / OS_TICK;
        if (b == 0) return 1'b0;
        if (b <= DBIT) return m_word[b-1];
        if (P == 1 && b == DBIT + 1) return m_par;
        return 1'b1;
    endfunction

    // driver: one clock of stimulus, model update at the edge, checks at the falling edge
    task automatic drive_cycle(input bit wr, input logic [DBIT-1:0] d);
        bit tk, done_now, pop_now, push_now;
        if (tick_hold)      tk = 1'b0;
        else if (tick_rand) tk = ($urandom_range(0, 2) == 0);
        else                tk = (tick_div == 3);
        tick_div   = (tick_div + 1) % 4;
        wr_en      = wr;
        din        = d;
        s_tick     = tk;
        parity_odd = 1'($urandom_range(0, 1));
        @(posedge clk);
        done_now = m_busy && tk && (m_left == 1);
        pop_now  = (!m_busy || done_now) && (exp_q.size() > 0);
        push_now = wr && (exp_q.size() < DEPTH);
        if (m_busy && tk) m_left--;
        if (done_now) m_busy = 1'b0;
        if (pop_now) begin
            m_word = exp_q.pop_front();
            m_par  = ^m_word ^ parity_odd;
            m_busy = 1'b1;
            m_left = FRAME_TICKS;
        end
        if (push_now) exp_q.push_back(d);
        m_done = done_now;
        @(negedge clk);
        wr_en = 1'b0;
        check_val("tx", tx, line_bit());
        check_val("busy", busy, m_busy);
        check_val("full", full, exp_q.size() == DEPTH);
        check_val("empty", empty, exp_q.size() == 0);
        check_val("done", tx_done_tick, m_done);
        if (tx_done_tick) done_seen++;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((m_busy || exp_q.size() > 0) && n < 20000) begin
            drive_cycle(1'b0, '0);
            n++;
        end
        repeat (2) drive_cycle(1'b0, '0);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_empty"}, empty, 1'b1);
    endtask

    initial begin
        int d0;
        int n;
        // reset values
        #1 reset = 1'b1;
        #2;
        check_val("rst_tx", tx, 1'b1);
        check_val("rst_empty", empty, 1'b1);
        check_val("rst_full", full, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", tx_done_tick, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // single 0x55 frame: line falls the clock after the write
        d0 = done_seen;
        drive_cycle(1'b1, 8'h55);
        check_val("t1_tx_before", tx, 1'b1);
        drive_cycle(1'b0, '0);
        check_val("t1_tx_fall", tx, 1'b0);
        wait_idle("t1");
        check_val("t1_done_cnt", done_seen - d0, 1);

        // six back-to-back writes: first pops at once, four fill the FIFO, sixth dropped
        d0 = done_seen;
        for (int i = 1; i <= 6; i++) begin
            drive_cycle(1'b1, DBIT'(i));
            if (i == 5) check_val("t3_full_after5", full, 1'b1);
        end
        wait_idle("t3");
        check_val("t3_done_cnt", done_seen - d0, 5);

        // tick stall mid-frame: everything freezes, then the frame finishes intact
        d0 = done_seen;
        drive_cycle(1'b1, 8'h3C);
        repeat (300) drive_cycle(1'b0, '0);
        tick_hold = 1'b1;
        repeat (500) drive_cycle(1'b0, '0);
        tick_hold = 1'b0;
        wait_idle("t6");
        check_val("t6_done_cnt", done_seen - d0, 1);

        // randomised writes and irregular tick spacing
        tick_rand = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            drive_cycle($urandom_range(0, 29) == 0, DBIT'($urandom));
        end
        wait_idle("rnd");
        tick_rand = 1'b0;

        // reset during data bit 3 of 0xA5 with two words queued
        drive_cycle(1'b1, 8'hA5);
        drive_cycle(1'b1, 8'h11);
        drive_cycle(1'b1, 8'h22);
        n = 0;
        while (!(m_busy && ((FRAME_TICKS - m_left) / OS_TICK) == 4 &&
                 ((FRAME_TICKS - m_left) % OS_TICK) == 8) && n < 3000) begin
            drive_cycle(1'b0, '0);
            n++;
        end
        check_val("t4_queued", empty, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_val("t4_tx_now", tx, 1'b1);
        check_val("t4_empty_now", empty, 1'b1);
        check_val("t4_busy_now", busy, 1'b0);
        exp_q.delete();
        m_busy = 1'b0;
        m_left = 0;
        @(negedge clk);
        reset = 1'b0;
        d0 = done_seen;
        repeat (2 * FRAME_TICKS * 4) drive_cycle(1'b0, '0);
        check_val("t4_no_done", done_seen - d0, 0);
        check_val("t4_tx_idle", tx, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
